key_entry: RTL



---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce.sv | 92 +++++++++
 rtl/key_entry.sv | 114 +++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared key codes and debounce state encoding for the keypad entry path.
package key_pkg;

  localparam logic [3:0] KEY_NONE    = 4'hD;
  localparam logic [3:0] KEY_START   = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hB;
  localparam logic [3:0] KEY_CONFIRM = 4'hC;
  localparam logic [3:0] KEY_UNUSED  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } db_state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Press/release debouncer: one key_event per full press/release cycle.
// key_event is combinational so the action lands on the same edge as the final stable sample.
module key_debounce
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_event = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key != KEY_NONE) begin
          cand_d  = key;
          cnt_d   = CNT_ONE;
          state_d = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (key == KEY_NONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            key_event = 1'b1;
            cnt_d     = '0;
            state_d   = ST_HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // A different key restarts the stability window on the new candidate.
          cand_d = key;
          cnt_d  = CNT_ONE;
        end
      end
      ST_HELD: begin
        if (key == KEY_NONE) begin
          cnt_d   = CNT_ONE;
          state_d = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        if (key != KEY_NONE) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign key_code = cand_q;

endmodule

// File: rtl/key_entry.sv
// Debounced keypad front end: BCD digit buffer, confirm/clear/start commands.
// Define KEY_ENTRY_BACKSPACE_EN to make key F delete the newest digit.
module key_entry
  import key_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   key,
  output logic [4*DIGITS-1:0]          digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         entry_valid,
  output logic [4*DIGITS-1:0]          entry_value,
  output logic                         start_pulse,
  output logic                         overflow
);

  localparam int              DW   = 4 * DIGITS;
  localparam int              NW   = $clog2(DIGITS + 1);
  localparam logic [NW-1:0]   FULL = NW'(DIGITS);

  logic          key_event;
  logic [3:0]    key_code;

  logic [DW-1:0] digits_q, digits_d;
  logic [NW-1:0] count_q, count_d;
  logic [DW-1:0] value_q, value_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          ovf_q, ovf_d;

  key_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_event(key_event),
    .key_code (key_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      count_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    ovf_d    = ovf_q;
    if (key_event) begin
      if (is_digit(key_code)) begin
        if (count_q != FULL) begin
          digits_d = (digits_q << 4) | DW'(key_code);
          count_d  = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_CLEAR: begin
            digits_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
          end
          KEY_CONFIRM: begin
            if (count_q != '0) begin
              value_d  = digits_q;
              valid_d  = 1'b1;
              digits_d = '0;
              count_d  = '0;
              ovf_d    = 1'b0;
            end
          end
          KEY_START: start_d = 1'b1;
`ifdef KEY_ENTRY_BACKSPACE_EN
          KEY_UNUSED: begin
            if (count_q != '0) begin
              digits_d = digits_q >> 4;
              count_d  = count_q - 1'b1;
              ovf_d    = 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign digits      = digits_q;
  assign count       = count_q;
  assign entry_valid = valid_q;
  assign entry_value = value_q;
  assign start_pulse = start_q;
  assign overflow    = ovf_q;

endmodule
